// File: rtl/logic_table_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_table_unit
// Description : Applies a runtime-programmable 2-input truth table bitwise
//               across two WIDTH-bit operands. The result sits in a
//               single-entry output register behind a valid/ready handshake.
//               A SWEEP mode replays the four truth-table rows of the current
//               function through the same output register.
//
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               func_we      - load func_in into the function register (IDLE only)
//               func_in[3:0] - new truth table, bit m = output for minterm {a,b}=m
//               in_valid     - operand pair presented
//               in_ready     - unit accepts operands
//               a, b         - operands, WIDTH bits
//               out_valid    - s holds a result
//               out_ready    - consumer accepts s
//               s            - registered result, WIDTH bits
//               sweep_start  - start a truth-table sweep (pulse)
//               sweep_busy   - sweep in progress
//               row_m[1:0]   - minterm index of the current sweep row
//               sweep_done   - one-cycle pulse after the last row is accepted
//               s_par        - parity of s (only with LOGIC_TABLE_PARITY_EN)
//
// Options     : define LOGIC_TABLE_PARITY_EN to add the s_par output.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_table_unit #(
  parameter int unsigned WIDTH    = 4,
  parameter logic [3:0]  FUNC_RST = 4'h7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             func_we,
  input  logic [3:0]       func_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [1:0]       row_m,
  output logic             sweep_done
`ifdef LOGIC_TABLE_PARITY_EN
  ,
  output logic             s_par
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       row_m_q, row_m_d;
  // Counts rows loaded so far (0..4); bit 2 set means all four rows are out.
  logic [2:0]       cnt_q, cnt_d;
  logic             sweep_done_q, sweep_done_d;
`ifdef LOGIC_TABLE_PARITY_EN
  logic             s_par_q, s_par_d;
`endif

  logic [WIDTH-1:0] core_s;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       load_row;
  logic             load_en;
  logic             room;
  logic             drain;

  // Bitwise truth-table lookup: each result bit selects func[{a[i],b[i]}].
  for (genvar i = 0; i < WIDTH; i++) begin : g_core
    assign core_s[i] = func_q[{a[i], b[i]}];
  end

  // The output register can take a new value when empty or being drained.
  assign room  = !out_valid_q || out_ready;
  assign drain = out_valid_q && out_ready;

  // sweep_start wins over a simultaneous operand, so refuse it in that cycle.
  assign in_ready = (state_q == ST_IDLE) && !sweep_start && room;

  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    s_d          = s_q;
    out_valid_d  = out_valid_q;
    row_m_d      = row_m_q;
    cnt_d        = cnt_q;
    sweep_done_d = 1'b0;
`ifdef LOGIC_TABLE_PARITY_EN
    s_par_d      = s_par_q;
`endif
    load_en      = 1'b0;
    load_val     = core_s;
    load_row     = 2'd0;

    case (state_q)
      ST_IDLE: begin
        // Operands accepted this cycle still see the old func (core_s uses func_q).
        if (func_we) begin
          func_d = func_in;
        end
        if (sweep_start) begin
          state_d = ST_SWEEP;
          cnt_d   = 3'd0;
        end else if (in_valid && room) begin
          load_en = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (!cnt_q[2]) begin
          if (room) begin
            load_en  = 1'b1;
            load_val = {WIDTH{func_q[cnt_q[1:0]]}};
            load_row = cnt_q[1:0];
            cnt_d    = cnt_q + 3'd1;
          end
        end else if (drain) begin
          // Last row taken by the consumer: leave the sweep.
          state_d      = ST_IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_en) begin
      s_d         = load_val;
      out_valid_d = 1'b1;
      row_m_d     = load_row;
`ifdef LOGIC_TABLE_PARITY_EN
      s_par_d     = ^load_val;
`endif
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      func_q       <= FUNC_RST;
      s_q          <= '0;
      out_valid_q  <= 1'b0;
      row_m_q      <= 2'd0;
      cnt_q        <= 3'd0;
      sweep_done_q <= 1'b0;
`ifdef LOGIC_TABLE_PARITY_EN
      s_par_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      s_q          <= s_d;
      out_valid_q  <= out_valid_d;
      row_m_q      <= row_m_d;
      cnt_q        <= cnt_d;
      sweep_done_q <= sweep_done_d;
`ifdef LOGIC_TABLE_PARITY_EN
      s_par_q      <= s_par_d;
`endif
    end
  end

  assign s          = s_q;
  assign out_valid  = out_valid_q;
  assign row_m      = row_m_q;
  assign sweep_busy = (state_q == ST_SWEEP);
  assign sweep_done = sweep_done_q;
`ifdef LOGIC_TABLE_PARITY_EN
  assign s_par      = s_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_table_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_table_unit
// Description : Self-checking bench for logic_table_unit. Operand traffic is
//               compared against a truth-table model with a one-entry output
//               buffer; sweeps are compared against the four expected rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_table_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         func_we;
  logic [3:0]   func_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         sweep_start;
  logic         sweep_busy;
  logic [1:0]   row_m;
  logic         sweep_done;
`ifdef LOGIC_TABLE_PARITY_EN
  logic         s_par;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0]   m_func;
  logic         m_v;
  logic [W-1:0] m_s;

  logic_table_unit #(.WIDTH(W), .FUNC_RST(4'h7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .func_we    (func_we),
    .func_in    (func_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .row_m      (row_m),
    .sweep_done (sweep_done)
`ifdef LOGIC_TABLE_PARITY_EN
    ,
    .s_par      (s_par)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Truth table: the output for a bit pair is bit (2*a + b) of f.
  function automatic logic [W-1:0] tt_apply(input logic [3:0] f, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [W-1:0] r;
    int idx;
    for (int i = 0; i < W; i++) begin
      idx  = 2 * int'(x[i]) + int'(y[i]);
      r[i] = f[idx];
    end
    return r;
  endfunction

  task automatic set_in(input logic va, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ordy, input logic fwe, input logic [3:0] fin);
    in_valid  = va;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    func_we   = fwe;
    func_in   = fin;
  endtask

  // Advance one clock (IDLE traffic only) and update the model from the
  // inputs that were present at that edge.
  task automatic step_model();
    logic         acc;
    logic [W-1:0] nxt;
    logic         fwe;
    logic [3:0]   fin;
    logic         ordy;
    acc  = in_valid && !sweep_start && (!m_v || out_ready);
    nxt  = tt_apply(m_func, a, b);
    fwe  = func_we;
    fin  = func_in;
    ordy = out_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      m_v = 1'b1;
      m_s = nxt;
    end else if (ordy) begin
      m_v = 1'b0;
    end
    if (fwe) m_func = fin;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sweep_start = 1'b0;
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h exp=0", s); end
    total++; if (row_m !== 2'd0) begin bad++; $display("FAIL reset_row_m got=%0d exp=0", row_m); end
    total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL reset_sweep_busy got=%b exp=0", sweep_busy); end
    total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sweep_done got=%b exp=0", sweep_done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef LOGIC_TABLE_PARITY_EN
    total++; if (s_par !== 1'b0) begin bad++; $display("FAIL reset_s_par got=%b exp=0", s_par); end
`endif
    @(negedge clk);
    rst_n  = 1'b1;
    m_func = 4'h7;
    m_v    = 1'b0;
    m_s    = '0;
  endtask

  task automatic test_nand_table();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] ex [4];
    va = '{4'h0, 4'h0, 4'hF, 4'hF};
    vb = '{4'h0, 4'hF, 4'h0, 4'hF};
    ex = '{4'hF, 4'hF, 4'hF, 4'h0};
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, va[k], vb[k], 1'b1, 1'b0, 4'h0);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nand_in_ready k=%0d got=%b exp=1", k, in_ready); end
      step_model();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nand_out_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (s !== ex[k]) begin bad++; $display("FAIL nand_s k=%0d got=%h exp=%h", k, s, ex[k]); end
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nand_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_func_write();
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h8);
    step_model();
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b1000) begin bad++; $display("FAIL func_and got=%b exp=1000", s); end
    // Same-cycle write: this operand must still see AND.
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b1, 4'h6);
    step_model();
    total++; if (s !== 4'b1000) begin bad++; $display("FAIL func_old_on_write got=%b exp=1000", s); end
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b0110) begin bad++; $display("FAIL func_xor got=%b exp=0110", s); end
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h2);
    step_model();
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b0010) begin bad++; $display("FAIL func_nota_and_b got=%b exp=0010", s); end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
  endtask

`ifdef LOGIC_TABLE_PARITY_EN
  task automatic test_parity();
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h6);
    step_model();
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b0110 || s_par !== 1'b0) begin bad++; $display("FAIL parity_xor got=%b/%b exp=0110/0", s, s_par); end
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h8);
    step_model();
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b1000 || s_par !== 1'b1) begin bad++; $display("FAIL parity_and got=%b/%b exp=1000/1", s, s_par); end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
  endtask
`endif

  task automatic test_random_traffic();
    for (int n = 0; n < 300; n++) begin
      set_in(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 4'($urandom));
      #1;
      total++; if (in_ready !== (!m_v || out_ready)) begin bad++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, (!m_v || out_ready)); end
      step_model();
      total++; if (out_valid !== m_v) begin bad++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, m_v); end
      if (m_v) begin
        total++; if (s !== m_s || row_m !== 2'd0) begin bad++; $display("FAIL rand_s n=%0d got=%h/%0d exp=%h/0", n, s, row_m, m_s); end
`ifdef LOGIC_TABLE_PARITY_EN
        total++; if (s_par !== ^m_s) begin bad++; $display("FAIL rand_s_par n=%0d got=%b exp=%b", n, s_par, ^m_s); end
`endif
      end
    end
    // Drain and restore NAND for the sweep tests.
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h7);
    step_model();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
  endtask

  task automatic test_sweep();
    logic [1:0]   got_row [$];
    logic [W-1:0] got_s   [$];
    logic         seen_done;
    int           dcount;
    logic [W-1:0] exp_s;
    seen_done = 1'b0;
    dcount    = 0;
    // An operand offered together with sweep_start must be refused.
    set_in(1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    sweep_start = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sweep_start_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    total++; if (out_valid !== 1'b0 || sweep_busy !== 1'b1) begin bad++; $display("FAIL sweep_entry got valid=%b busy=%b exp valid=0 busy=1", out_valid, sweep_busy); end
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (sweep_done === 1'b1) begin
        seen_done = 1'b1;
        dcount++;
        in_valid = 1'b0;
      end else begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sweep_in_ready c=%0d got=%b exp=0", c, in_ready); end
        if (out_valid === 1'b1) begin
          got_row.push_back(row_m);
          got_s.push_back(s);
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    total++; if (!seen_done) begin bad++; $display("FAIL sweep_timeout got=no_done exp=done"); end
    total++; if (got_row.size() != 4) begin bad++; $display("FAIL sweep_rows got=%0d exp=4", got_row.size()); end
    for (int k = 0; k < 4 && k < got_row.size(); k++) begin
      exp_s = m_func[k] ? '1 : '0;
      total++; if (got_row[k] !== 2'(k) || got_s[k] !== exp_s) begin bad++; $display("FAIL sweep_row k=%0d got=(%0d,%h) exp=(%0d,%h)", k, got_row[k], got_s[k], k, exp_s); end
    end
    total++; if (sweep_busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL sweep_exit got busy=%b valid=%b exp 0/0", sweep_busy, out_valid); end
    repeat (4) begin
      @(posedge clk);
      #1;
      if (sweep_done === 1'b1) dcount++;
    end
    total++; if (dcount != 1) begin bad++; $display("FAIL sweep_done_count got=%0d exp=1", dcount); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sweep_after_in_ready got=%b exp=1", in_ready); end
    m_v = 1'b0;
  endtask

  task automatic test_sweep_stall();
    logic [1:0]   got_row [$];
    logic [W-1:0] got_s   [$];
    logic         seen_done;
    logic         hold_pending;
    logic [W-1:0] held_s;
    logic [1:0]   held_row;
    int           stalls;
    logic [W-1:0] exp_s;
    seen_done    = 1'b0;
    hold_pending = 1'b0;
    stalls       = 0;
    held_s       = '0;
    held_row     = 2'd0;
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    sweep_start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (hold_pending) begin
        hold_pending = 1'b0;
        total++; if (out_valid !== 1'b1 || s !== held_s || row_m !== held_row) begin bad++; $display("FAIL stall_hold got=(%b,%0d,%h) exp=(1,%0d,%h)", out_valid, row_m, s, held_row, held_s); end
      end
      // Second cycle: repeated sweep_start and a func write, both ignored.
      sweep_start = (c == 0);
      func_we     = (c == 0);
      func_in     = 4'h0;
      if (sweep_done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (out_valid === 1'b1 && row_m === 2'd1 && stalls < 3) begin
          out_ready    = 1'b0;
          stalls++;
          held_s       = s;
          held_row     = row_m;
          hold_pending = 1'b1;
        end else begin
          out_ready = 1'b1;
          if (out_valid === 1'b1) begin
            got_row.push_back(row_m);
            got_s.push_back(s);
          end
        end
        @(posedge clk);
        #1;
      end
    end
    sweep_start = 1'b0;
    func_we     = 1'b0;
    out_ready   = 1'b1;
    total++; if (!seen_done) begin bad++; $display("FAIL stall_timeout got=no_done exp=done"); end
    total++; if (stalls != 3) begin bad++; $display("FAIL stall_count got=%0d exp=3", stalls); end
    total++; if (got_row.size() != 4) begin bad++; $display("FAIL stall_rows got=%0d exp=4", got_row.size()); end
    for (int k = 0; k < 4 && k < got_row.size(); k++) begin
      exp_s = m_func[k] ? '1 : '0;
      total++; if (got_row[k] !== 2'(k) || got_s[k] !== exp_s) begin bad++; $display("FAIL stall_row k=%0d got=(%0d,%h) exp=(%0d,%h)", k, got_row[k], got_s[k], k, exp_s); end
    end
    m_v = 1'b0;
    // Function must still be NAND.
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b0111 || row_m !== 2'd0) begin bad++; $display("FAIL stall_func_kept got=%b/%0d exp=0111/0", s, row_m); end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
  endtask

  task automatic test_sweep_reset();
    logic found;
    int   dcount;
    found  = 1'b0;
    dcount = 0;
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'h8);
    step_model();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    sweep_start = 1'b1;
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid === 1'b1 && row_m === 2'd2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL sreset_row2_timeout got=missing exp=row2"); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || s !== '0) begin bad++; $display("FAIL sreset_out got=%b/%h exp=0/0", out_valid, s); end
    total++; if (sweep_busy !== 1'b0 || row_m !== 2'd0 || sweep_done !== 1'b0) begin bad++; $display("FAIL sreset_ctl got busy=%b row=%0d done=%b exp 0/0/0", sweep_busy, row_m, sweep_done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sreset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n  = 1'b1;
    m_func = 4'h7;
    m_v    = 1'b0;
    m_s    = '0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (sweep_done !== 1'b0 || out_valid !== 1'b0) dcount++;
    end
    total++; if (dcount != 0) begin bad++; $display("FAIL sreset_quiet got=%0d_events exp=0", dcount); end
    set_in(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'h0);
    step_model();
    total++; if (s !== 4'b0111 || s !== m_s) begin bad++; $display("FAIL sreset_func got=%b exp=0111", s); end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'h0);
    step_model();
  endtask

  initial begin
    test_reset();
    test_nand_table();
    test_func_write();
`ifdef LOGIC_TABLE_PARITY_EN
    test_parity();
`endif
    test_random_traffic();
    test_sweep();
    test_sweep_stall();
    test_sweep_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
